// File: rtl/mem_stage_unit_if.sv
// Interface bundling the EX/MEM-side controls, the data-memory bus and the
// MEM/WB-side results of mem_stage_unit.
//
// Flow control: stall_OUT is the only back-pressure signal. While it is 1 the
// producer must hold the EM register (and everything upstream) so the same
// operation is presented again next cycle. An operation is accepted on any
// rising edge where stall_OUT is 0. wb_valid_OUT is a one-cycle qualifier for
// read_data_OUT and has no ready counterpart; the consumer must take it then.
//
// state_dbg mirrors the internal FSM state (0 = IDLE, 1 = SECOND).
interface mem_stage_unit_if #(
    parameter int ADDR_W = 11
) ();
    logic              mem_read_IN;
    logic              mem_write_IN;
    logic              push_IN;
    logic              pop_IN;
    logic              wide_IN;
    logic [15:0]       address_IN;
    logic [15:0]       result_IN;
    logic [15:0]       reg_dst_value_IN;
    logic [31:0]       sp_IN;
    logic              sp_sel_IN;
    logic [15:0]       dmem_rdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_wdata;
    logic              dmem_we;
    logic [31:0]       read_data_OUT;
    logic [31:0]       sp_OUT;
    logic              wb_valid_OUT;
    logic              stall_OUT;
    logic              exc_OUT;
    logic              state_dbg;

    // Memory stage side
    modport slave (
        input  mem_read_IN, mem_write_IN, push_IN, pop_IN, wide_IN,
        input  address_IN, result_IN, reg_dst_value_IN, sp_IN, sp_sel_IN,
        input  dmem_rdata,
        output dmem_addr, dmem_wdata, dmem_we,
        output read_data_OUT, sp_OUT, wb_valid_OUT, stall_OUT, exc_OUT,
        output state_dbg
    );

    // Pipeline / memory side
    modport master (
        output mem_read_IN, mem_write_IN, push_IN, pop_IN, wide_IN,
        output address_IN, result_IN, reg_dst_value_IN, sp_IN, sp_sel_IN,
        output dmem_rdata,
        input  dmem_addr, dmem_wdata, dmem_we,
        input  read_data_OUT, sp_OUT, wb_valid_OUT, stall_OUT, exc_OUT,
        input  state_dbg
    );
endinterface

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory stage behind the EX/MEM register.
// Decodes EM control bits (priority sp_sel > push > pop > mem_write > mem_read),
// drives a 16-bit data memory, keeps the 32-bit stack pointer (grows down,
// points at the next free word) and splits 32-bit accesses into two word
// cycles, stalling upstream during the first one.
// Optional feature: define MEM_BOUNDS_CHECK_EN to block and flag accesses
// whose address has bits set above ADDR_W.
module mem_stage_unit #(
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] SP_RESET = 32'h0000_07FF
) (
    input  logic            clk,
    input  logic            reset,
    mem_stage_unit_if.slave em
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LDSP,
        OP_PUSH,
        OP_POP,
        OP_STORE,
        OP_LOAD
    } op_t;

    state_t      state_q, state_d;
    op_t         op_in;
    op_t         op_q, op_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] sp_q, sp_d;
    logic [31:0] rd_q, rd_d;
    logic        wb_q, wb_d;

    logic [31:0] acc_addr;
    logic        access;
    logic        we_c;
    logic [15:0] wdata_c;
    logic        stall_c;

`ifdef MEM_BOUNDS_CHECK_EN
    logic        fault;
    logic        exc_q;
`else
    logic        unused_upper;
`endif

    // Priority decode of the EM control bits; lower-priority bits are dropped
    always_comb begin
        op_in = OP_NONE;
        if (em.sp_sel_IN)         op_in = OP_LDSP;
        else if (em.push_IN)      op_in = OP_PUSH;
        else if (em.pop_IN)       op_in = OP_POP;
        else if (em.mem_write_IN) op_in = OP_STORE;
        else if (em.mem_read_IN)  op_in = OP_LOAD;
    end

    // Next-state, memory bus and result computation for both FSM states
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        sp_d     = sp_q;
        rd_d     = rd_q;
        wb_d     = 1'b0;
        acc_addr = 32'd0;
        access   = 1'b0;
        we_c     = 1'b0;
        wdata_c  = 16'd0;
        stall_c  = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        fault    = 1'b0;
`endif

        if (state_q == IDLE) begin
            case (op_in)
                OP_LDSP: begin
                    sp_d = em.sp_IN;
                end
                OP_PUSH: begin
                    // Wide push stores the high word first, at the top slot
                    access   = 1'b1;
                    acc_addr = sp_q;
                    we_c     = 1'b1;
                    wdata_c  = em.wide_IN ? em.result_IN : em.reg_dst_value_IN;
                    if (!em.wide_IN) sp_d = sp_q - 32'd1;
                end
                OP_POP: begin
                    access   = 1'b1;
                    acc_addr = sp_q + 32'd1;
                    if (!em.wide_IN) begin
                        rd_d = {16'h0000, em.dmem_rdata};
                        wb_d = 1'b1;
                        sp_d = sp_q + 32'd1;
                    end
                end
                OP_STORE: begin
                    access   = 1'b1;
                    acc_addr = {16'h0000, em.address_IN};
                    we_c     = 1'b1;
                    wdata_c  = em.reg_dst_value_IN;
                end
                OP_LOAD: begin
                    access   = 1'b1;
                    acc_addr = {16'h0000, em.address_IN};
                    if (!em.wide_IN) begin
                        rd_d = {16'h0000, em.dmem_rdata};
                        wb_d = 1'b1;
                    end
                end
                default: ;
            endcase

            // Wide memory op: latch everything the second cycle needs, since
            // the EM inputs are not trusted during SECOND
            if (em.wide_IN && (op_in != OP_NONE) && (op_in != OP_LDSP)) begin
                state_d = SECOND;
                stall_c = 1'b1;
                op_d    = op_in;
                hi_d    = em.result_IN;
                addr_d  = em.address_IN;
                lo_d    = ((op_in == OP_POP) || (op_in == OP_LOAD)) ?
                          em.dmem_rdata : em.reg_dst_value_IN;
            end
        end else begin
            state_d = IDLE;
            case (op_q)
                OP_PUSH: begin
                    access   = 1'b1;
                    acc_addr = sp_q - 32'd1;
                    we_c     = 1'b1;
                    wdata_c  = lo_q;
                    sp_d     = sp_q - 32'd2;
                end
                OP_POP: begin
                    access   = 1'b1;
                    acc_addr = sp_q + 32'd2;
                    rd_d     = {em.dmem_rdata, lo_q};
                    wb_d     = 1'b1;
                    sp_d     = sp_q + 32'd2;
                end
                OP_STORE: begin
                    access   = 1'b1;
                    acc_addr = {16'h0000, addr_q + 16'd1};
                    we_c     = 1'b1;
                    wdata_c  = hi_q;
                end
                OP_LOAD: begin
                    access   = 1'b1;
                    acc_addr = {16'h0000, addr_q + 16'd1};
                    rd_d     = {em.dmem_rdata, lo_q};
                    wb_d     = 1'b1;
                end
                default: ;
            endcase
        end

`ifdef MEM_BOUNDS_CHECK_EN
        // Out-of-range access: suppress the write, drop any wide op and
        // leave architectural state (SP, read data) untouched
        fault = access && (acc_addr[31:ADDR_W] != '0);
        if (fault) begin
            we_c    = 1'b0;
            stall_c = 1'b0;
            state_d = IDLE;
            sp_d    = sp_q;
            rd_d    = rd_q;
            wb_d    = 1'b0;
        end
`endif
    end

`ifndef MEM_BOUNDS_CHECK_EN
    // Upper address bits are intentionally dropped without a check
    assign unused_upper = ^{access, acc_addr[31:ADDR_W]};
`endif

    // FSM state register; reset aborts any wide op in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latched operands, stack pointer and registered results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_NONE;
            hi_q   <= 16'd0;
            lo_q   <= 16'd0;
            addr_q <= 16'd0;
            sp_q   <= SP_RESET;
            rd_q   <= 32'd0;
            wb_q   <= 1'b0;
        end else begin
            op_q   <= op_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            addr_q <= addr_d;
            sp_q   <= sp_d;
            rd_q   <= rd_d;
            wb_q   <= wb_d;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // One-cycle exception pulse for a blocked access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) exc_q <= 1'b0;
        else        exc_q <= fault;
    end
    assign em.exc_OUT = exc_q;
`else
    assign em.exc_OUT = 1'b0;
`endif

    // Write enable is gated by reset so nothing is written while it is held
    assign em.dmem_we       = we_c & reset;
    assign em.dmem_addr     = acc_addr[ADDR_W-1:0];
    assign em.dmem_wdata    = wdata_c;
    assign em.stall_OUT     = stall_c;
    assign em.read_data_OUT = rd_q;
    assign em.sp_OUT        = sp_q;
    assign em.wb_valid_OUT  = wb_q;
    assign em.state_dbg     = state_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a behavioural data memory and a
// read-result scoreboard.
module tb_mem_stage_unit;

  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [15:0] before_v;
  logic [15:0] a_v;
  logic [15:0] d_v;

  mem_stage_unit_if #(.ADDR_W(ADDR_W)) em ();

  mem_stage_unit #(
    .ADDR_W  (ADDR_W),
    .SP_RESET(32'h0000_07FF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .em   (em)
  );

  // clock
  always #5 clk = ~clk;

  // data memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (em.dmem_we) mem[em.dmem_addr] <= em.dmem_wdata;
  end
  assign em.dmem_rdata = mem[em.dmem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    em.mem_read_IN      = 1'b0;
    em.mem_write_IN     = 1'b0;
    em.push_IN          = 1'b0;
    em.pop_IN           = 1'b0;
    em.wide_IN          = 1'b0;
    em.sp_sel_IN        = 1'b0;
    em.address_IN       = 16'h0000;
    em.result_IN        = 16'h0000;
    em.reg_dst_value_IN = 16'h0000;
    em.sp_IN            = 32'h0;
  endtask

  task automatic set_op(input logic psh, input logic pp, input logic mw, input logic mr,
                        input logic wd, input logic sps, input logic [15:0] addr,
                        input logic [15:0] res, input logic [15:0] rdv, input logic [31:0] spv);
    em.push_IN          = psh;
    em.pop_IN           = pp;
    em.mem_write_IN     = mw;
    em.mem_read_IN      = mr;
    em.wide_IN          = wd;
    em.sp_sel_IN        = sps;
    em.address_IN       = addr;
    em.result_IN        = res;
    em.reg_dst_value_IN = rdv;
    em.sp_IN            = spv;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // scoreboard: every wb_valid pulse consumes one expected read result
  always @(negedge clk) begin
    if (reset && em.wb_valid_OUT) begin
      if (exp_q.size() == 0) check("wb_unexpected", 32'(em.wb_valid_OUT), 32'd0);
      else check("read_data", em.read_data_OUT, exp_q.pop_front());
    end
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_sp", em.sp_OUT, 32'h7FF);
    check("rst_rd", em.read_data_OUT, 32'h0);
    check("rst_wb", 32'(em.wb_valid_OUT), 32'd0);
    check("rst_we", 32'(em.dmem_we), 32'd0);
    check("rst_exc", 32'(em.exc_OUT), 32'd0);
    check("rst_state", 32'(em.state_dbg), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // narrow push then narrow pop
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'hBEEF, 32'h0);
    #1;
    check("push_stall", 32'(em.stall_OUT), 32'd0);
    check("push_we", 32'(em.dmem_we), 32'd1);
    check("push_addr", 32'(em.dmem_addr), 32'h7FF);
    cycle();
    idle_inputs();
    check("push_mem", 32'(mem[11'h7FF]), 32'hBEEF);
    check("push_sp", em.sp_OUT, 32'h7FE);
    exp_q.push_back(32'h0000_BEEF);
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0);
    #1;
    check("pop_addr", 32'(em.dmem_addr), 32'h7FF);
    cycle();
    idle_inputs();
    check("pop_sp", em.sp_OUT, 32'h7FF);
    check("pop_wb", 32'(em.wb_valid_OUT), 32'd1);
    cycle();
    check("pop_wb_pulse", 32'(em.wb_valid_OUT), 32'd0);

    // wide push then wide pop
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h1234, 16'h5678, 32'h0);
    #1;
    check("wpush_stall1", 32'(em.stall_OUT), 32'd1);
    cycle();
    check("wpush_state", 32'(em.state_dbg), 32'd1);
    check("wpush_sp_mid", em.sp_OUT, 32'h7FF);
    #1;
    check("wpush_stall2", 32'(em.stall_OUT), 32'd0);
    check("wpush_addr2", 32'(em.dmem_addr), 32'h7FE);
    cycle();
    idle_inputs();
    check("wpush_hi", 32'(mem[11'h7FF]), 32'h1234);
    check("wpush_lo", 32'(mem[11'h7FE]), 32'h5678);
    check("wpush_sp", em.sp_OUT, 32'h7FD);
    exp_q.push_back(32'h1234_5678);
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0);
    #1;
    check("wpop_stall", 32'(em.stall_OUT), 32'd1);
    cycle();
    check("wpop_wb_mid", 32'(em.wb_valid_OUT), 32'd0);
    cycle();
    idle_inputs();
    check("wpop_sp", em.sp_OUT, 32'h7FF);

    // push has priority over mem_write
    before_v = mem[11'h300];
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0, 16'hCAFE, 32'h0);
    cycle();
    idle_inputs();
    check("prio_push_mem", 32'(mem[11'h7FF]), 32'hCAFE);
    check("prio_store_skip", 32'(mem[11'h300]), 32'(before_v));
    check("prio_sp", em.sp_OUT, 32'h7FE);
    exp_q.push_back(32'h0000_CAFE);
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0);
    cycle();
    idle_inputs();
    check("prio_pop_sp", em.sp_OUT, 32'h7FF);

    // reset asserted during SECOND of a wide push
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'hAAAA, 16'hBBBB, 32'h0);
    cycle();
    check("abort_state", 32'(em.state_dbg), 32'd1);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("abort_we", 32'(em.dmem_we), 32'd0);
    check("abort_sp", em.sp_OUT, 32'h7FF);
    check("abort_rd", em.read_data_OUT, 32'h0);
    check("abort_wb", 32'(em.wb_valid_OUT), 32'd0);
    check("abort_state0", 32'(em.state_dbg), 32'd0);
    @(negedge clk);
    check("abort_lo_kept", 32'(mem[11'h7FE]), 32'h5678);
    check("abort_hi_written", 32'(mem[11'h7FF]), 32'hAAAA);
    reset = 1'b1;
    @(negedge clk);

    // LDSP to zero then push wraps SP
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 32'h0);
    cycle();
    check("ldsp_sp", em.sp_OUT, 32'h0);
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1111, 32'h0);
    #1;
    check("wrap_addr", 32'(em.dmem_addr), 32'h0);
    cycle();
    idle_inputs();
    check("wrap_sp", em.sp_OUT, 32'hFFFF_FFFF);
    check("wrap_mem", 32'(mem[11'h000]), 32'h1111);

    // store just past the memory range
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0, 16'h2222, 32'h0);
    #1;
    check("oob_addr", 32'(em.dmem_addr), 32'h0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_we", 32'(em.dmem_we), 32'd0);
    cycle();
    idle_inputs();
    check("oob_exc", 32'(em.exc_OUT), 32'd1);
    check("oob_mem", 32'(mem[11'h000]), 32'h1111);
    cycle();
    check("oob_exc_pulse", 32'(em.exc_OUT), 32'd0);
`else
    check("oob_we", 32'(em.dmem_we), 32'd1);
    cycle();
    idle_inputs();
    check("oob_exc", 32'(em.exc_OUT), 32'd0);
    check("oob_mem", 32'(mem[11'h000]), 32'h2222);
`endif

    // wide store / wide load / narrow load of the high word
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h9ABC, 16'hDEF0, 32'h0);
    #1;
    check("wst_stall", 32'(em.stall_OUT), 32'd1);
    cycle();
    cycle();
    idle_inputs();
    check("wst_lo", 32'(mem[11'h010]), 32'hDEF0);
    check("wst_hi", 32'(mem[11'h011]), 32'h9ABC);
    exp_q.push_back(32'h9ABC_DEF0);
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 32'h0);
    cycle();
    cycle();
    exp_q.push_back(32'h0000_9ABC);
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0, 16'h0, 32'h0);
    cycle();
    idle_inputs();

    // randomized narrow store/load pairs
    for (int i = 0; i < 4; i++) begin
      a_v = 16'h0100 + 16'(i * 16) + 16'($urandom_range(0, 15));
      d_v = 16'($urandom_range(0, 16'hFFFF));
      set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a_v, 16'h0, d_v, 32'h0);
      cycle();
      idle_inputs();
      check("rnd_store", 32'(mem[a_v[10:0]]), 32'(d_v));
      exp_q.push_back({16'h0000, d_v});
      set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a_v, 16'h0, 16'h0, 32'h0);
      cycle();
      idle_inputs();
    end

    repeat (2) cycle();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
